// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, error bit
// indices and the default bit period.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam int ERR_PARITY = 0;
  localparam int ERR_FRAME  = 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input; both flops reset to the idle
// (high) line level so no false start edge is seen after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, 1 stop bit, optional parity bit selected by the
// UART_PARITY_EN macro (undefined: 8N1). Current FSM state is exported on fsm_state.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] UART_data,
  output logic       UART_data_valid,
  output logic [1:0] UART_errors,
  output logic       UART_errors_valid,
  output logic [2:0] fsm_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT out of range 4..65535");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  logic          rx_s;
  logic          rx_prev;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_err;

`ifdef UART_PARITY_EN
  localparam logic [2:0] AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] AFTER_DATA = ST_STOP;
  assign par_err = 1'b0;
`endif

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign fsm_state = state;

  // Outputs have no ready: UART_data_valid / UART_errors_valid are single-cycle
  // pulses raised the cycle after the stop-bit sample; data/errors then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      rx_prev           <= 1'b1;
      UART_data         <= '0;
      UART_data_valid   <= 1'b0;
      UART_errors       <= '0;
      UART_errors_valid <= 1'b0;
`ifdef UART_PARITY_EN
      par_err           <= 1'b0;
`endif
    end else begin
      rx_prev           <= rx_s;
      UART_data_valid   <= 1'b0;
      UART_errors_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == HALF_CNT) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == LAST_CNT) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= AFTER_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt     <= '0;
            par_err <= ^shreg ^ rx_s ^ PARITY_ODD[0];
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rx_s && !par_err) begin
              UART_data       <= shreg;
              UART_data_valid <= 1'b1;
              state           <= ST_IDLE;
            end else begin
              UART_errors[ERR_FRAME]  <= ~rx_s;
              UART_errors[ERR_PARITY] <= par_err;
              UART_errors_valid       <= 1'b1;
              // A low stop bit is treated as a line break until rx returns high.
              state <= rx_s ? ST_IDLE : ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16; parity cases run when
// UART_PARITY_EN is defined.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam logic PAR_ODD_BIT = 1'b0;
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] data;
  logic       data_valid;
  logic [1:0] errs;
  logic       errs_valid;
  logic [2:0] fsm_state;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx                (rx),
    .UART_data         (data),
    .UART_data_valid   (data_valid),
    .UART_errors       (errs),
    .UART_errors_valid (errs_valid),
    .fsm_state         (fsm_state)
  );

  // scoreboard: {is_error, errors[1:0], data[7:0]}
  logic [10:0] exp_q[$];
  logic [10:0] exp_e;
  logic [7:0]  last_data = 8'h00;
  logic [1:0]  last_err = 2'b00;
  logic        prev_pulse = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (data_valid || errs_valid) begin
      check("valid_exclusive", 32'(data_valid & errs_valid), 32'd0);
      check("no_back_to_back_pulse", 32'(prev_pulse), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({data_valid, errs_valid}), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e[10]) begin
          check("err_pulse", 32'(errs_valid), 32'd1);
          check("err_bits", 32'(errs), 32'(exp_e[9:8]));
          check("data_hold_on_err", 32'(data), 32'(last_data));
          last_err = exp_e[9:8];
        end else begin
          check("data_pulse", 32'(data_valid), 32'd1);
          check("rx_byte", 32'(data), 32'(exp_e[7:0]));
          check("err_hold_on_data", 32'(errs), 32'(last_err));
          last_data = exp_e[7:0];
        end
      end
    end
    prev_pulse = data_valid | errs_valid;
  end

  // driver tasks (called on a negedge)
  task automatic hold_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    logic pf;
    pf = par_flip & PAR_EN;
    if (!stop) exp_q.push_back({1'b1, 1'b1, pf, 8'h00});
    else if (pf) exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h00});
    else exp_q.push_back({1'b0, 2'b00, d});
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    if (PAR_EN) hold_bit(^d ^ PAR_ODD_BIT ^ par_flip);
    hold_bit(stop);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_errors"}, 32'(errs), 32'd0);
    check({tag, "_errors_valid"}, 32'(errs_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] d3c;
    rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(10);

    // plain good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);

    // parity error keeps previous data
    if (PAR_EN) begin
      send_frame(8'h03, 1'b1, 1'b1);
      idle(20);
    end

    // framing error followed by a line break, then recovery
    send_frame(8'h5A, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 - CPB) @(negedge clk);
    check("break_state", 32'(fsm_state), 32'(ST_BREAK));
    idle(20);
    check("break_exit_idle", 32'(fsm_state), 32'(ST_IDLE));
    send_frame(8'h11, 1'b1, 1'b0);
    idle(20);

    // false start: 5-cycle glitch
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    check("false_start_idle", 32'(fsm_state), 32'(ST_IDLE));
    check("false_start_data_hold", 32'(data), 32'(last_data));

    // back-to-back frames with no idle gap
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);

    // reset during bit 4 aborts the frame
    d3c = 8'h3C;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(d3c[i]);
    rx = d3c[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_frame_reset");
    rx = 1'b1;
    last_data = 8'h00;
    last_err = 2'b00;
    rst = 1'b0;
    idle(20);
    check("post_reset_no_pulse_state", 32'(fsm_state), 32'(ST_IDLE));
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(5);

    // random back-to-back frames
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, 1'b0);
    end
    idle(40);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
